// File: rtl/id_ex_alu_issue_pkg.sv
// Shared ALU operation codes, MIPS opcode/funct constants and decode types for the ID/EX issue stage.
package id_ex_alu_issue_pkg;

    // ALU operation encoding as understood by the EX-stage Alu
    localparam logic [5:0] ALU_NONE = 6'd0;
    localparam logic [5:0] ALU_ADD  = 6'd1;
    localparam logic [5:0] ALU_SUB  = 6'd2;
    localparam logic [5:0] ALU_AND  = 6'd3;
    localparam logic [5:0] ALU_OR   = 6'd4;
    localparam logic [5:0] ALU_NOR  = 6'd5;
    localparam logic [5:0] ALU_SLT  = 6'd6;
    localparam logic [5:0] ALU_SLL  = 6'd7;
    localparam logic [5:0] ALU_SRL  = 6'd8;
    localparam logic [5:0] ALU_SRA  = 6'd9;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic {
        A_RS,
        A_RT
    } a_sel_t;

    typedef enum logic [1:0] {
        B_RT,
        B_SHAMT,
        B_SEXT,
        B_ZEXT
    } b_sel_t;

    typedef struct packed {
        logic [5:0] aluoper;
        a_sel_t     a_sel;
        b_sel_t     b_sel;
        logic       wr_en;
        logic [4:0] wr_addr;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/id_ex_alu_issue_alu_ctrl_dec.sv
// Combinational instruction decode: opcode/funct -> ALU op, operand selects, write-back target, illegal flag.
// I-type ALU ops (addi/slti/andi/ori) decode only when IMM_ALU_OPS_EN is defined.
module alu_ctrl_dec
    import id_ex_alu_issue_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [4:0] rt,
    input  logic [4:0] rd,
    input  logic [5:0] funct,
    output dec_t       dec
);

    always_comb begin
        dec         = '0;
        dec.aluoper = ALU_NONE;
        dec.a_sel   = A_RS;
        dec.b_sel   = B_RT;
        case (opcode)
            OP_RTYPE: begin
                dec.wr_en   = 1'b1;
                dec.wr_addr = rd;
                case (funct)
                    FN_ADD, FN_ADDU: dec.aluoper = ALU_ADD;
                    FN_SUB, FN_SUBU: dec.aluoper = ALU_SUB;
                    FN_AND:          dec.aluoper = ALU_AND;
                    FN_OR:           dec.aluoper = ALU_OR;
                    FN_NOR:          dec.aluoper = ALU_NOR;
                    FN_SLT:          dec.aluoper = ALU_SLT;
                    FN_SLL, FN_SRL, FN_SRA: begin
                        dec.a_sel   = A_RT;
                        dec.b_sel   = B_SHAMT;
                        dec.aluoper = (funct == FN_SLL) ? ALU_SLL :
                                      (funct == FN_SRL) ? ALU_SRL : ALU_SRA;
                    end
                    default: begin
                        dec.illegal = 1'b1;
                        dec.wr_en   = 1'b0;
                        dec.wr_addr = 5'd0;
                    end
                endcase
            end
            OP_LW: begin
                dec.aluoper = ALU_ADD;
                dec.b_sel   = B_SEXT;
                dec.wr_en   = 1'b1;
                dec.wr_addr = rt;
            end
            OP_SW: begin
                dec.aluoper = ALU_ADD;
                dec.b_sel   = B_SEXT;
            end
            OP_BEQ: dec.aluoper = ALU_SUB;
`ifdef IMM_ALU_OPS_EN
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
                dec.wr_en   = 1'b1;
                dec.wr_addr = rt;
                case (opcode)
                    OP_ADDI: begin dec.aluoper = ALU_ADD; dec.b_sel = B_SEXT; end
                    OP_SLTI: begin dec.aluoper = ALU_SLT; dec.b_sel = B_SEXT; end
                    OP_ANDI: begin dec.aluoper = ALU_AND; dec.b_sel = B_ZEXT; end
                    default: begin dec.aluoper = ALU_OR;  dec.b_sel = B_ZEXT; end
                endcase
            end
`endif
            default: dec.illegal = 1'b1;
        endcase
        // $zero is hard-wired, so a write there is dropped rather than issued
        if (dec.wr_addr == 5'd0) begin
            dec.wr_en = 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX pipeline register feeding the ALU: operand muxing, stall/flush priority and a saturating bubble counter.
// Optional I-type ALU decode is enabled with the IMM_ALU_OPS_EN macro.
module id_ex_alu_issue
    import id_ex_alu_issue_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      instr,
    input  logic [W-1:0]     rs_val,
    input  logic [W-1:0]     rt_val,
    input  logic             stall,
    input  logic             flush,
    output logic             ex_valid,
    output logic [W-1:0]     ex_A,
    output logic [W-1:0]     ex_B,
    output logic [5:0]       ex_ALUoper,
    output logic             ex_wr_en,
    output logic [4:0]       ex_wr_addr,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] bubble_cnt
);

    dec_t           dec;
    logic [W-1:0]   imm_sext;
    logic [W-1:0]   imm_zext;
    logic [W-1:0]   shamt_zext;
    logic [W-1:0]   a_next;
    logic [W-1:0]   b_next;
    logic           bubble_next;
    logic           load_en;

    logic             valid_reg;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [5:0]       aluoper_reg;
    logic             wr_en_reg;
    logic [4:0]       wr_addr_reg;
    logic             illegal_reg;
    logic [CNT_W-1:0] bubble_cnt_reg;

    alu_ctrl_dec u_dec (
        .opcode (instr[31:26]),
        .rt     (instr[20:16]),
        .rd     (instr[15:11]),
        .funct  (instr[5:0]),
        .dec    (dec)
    );

    assign imm_sext[15:0] = instr[15:0];
    generate
        for (genvar gi = 16; gi < W; gi++) begin : g_sext
            assign imm_sext[gi] = instr[15];
        end
    endgenerate
    assign imm_zext   = {{(W-16){1'b0}}, instr[15:0]};
    assign shamt_zext = {{(W-5){1'b0}}, instr[10:6]};

    always_comb begin
        a_next = (dec.a_sel == A_RT) ? rt_val : rs_val;
        case (dec.b_sel)
            B_SHAMT: b_next = shamt_zext;
            B_SEXT:  b_next = imm_sext;
            B_ZEXT:  b_next = imm_zext;
            default: b_next = rt_val;
        endcase
    end

    // flush wins over stall; the nop word 0 is not a real instruction
    assign load_en     = flush | ~stall;
    assign bubble_next = flush | ~in_valid | (instr == 32'h0) | dec.illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg      <= 1'b0;
            a_reg          <= '0;
            b_reg          <= '0;
            aluoper_reg    <= ALU_NONE;
            wr_en_reg      <= 1'b0;
            wr_addr_reg    <= 5'd0;
            illegal_reg    <= 1'b0;
            bubble_cnt_reg <= '0;
        end else if (load_en) begin
            if (bubble_next) begin
                valid_reg   <= 1'b0;
                a_reg       <= '0;
                b_reg       <= '0;
                aluoper_reg <= ALU_NONE;
                wr_en_reg   <= 1'b0;
                wr_addr_reg <= 5'd0;
                illegal_reg <= ~flush & in_valid & dec.illegal;
                if (bubble_cnt_reg != {CNT_W{1'b1}}) begin
                    bubble_cnt_reg <= bubble_cnt_reg + 1'b1;
                end
            end else begin
                valid_reg   <= 1'b1;
                a_reg       <= a_next;
                b_reg       <= b_next;
                aluoper_reg <= dec.aluoper;
                wr_en_reg   <= dec.wr_en;
                wr_addr_reg <= dec.wr_addr;
                illegal_reg <= 1'b0;
            end
        end
    end

    assign ex_valid   = valid_reg;
    assign ex_A       = a_reg;
    assign ex_B       = b_reg;
    assign ex_ALUoper = aluoper_reg;
    assign ex_wr_en   = wr_en_reg;
    assign ex_wr_addr = wr_addr_reg;
    assign ex_illegal = illegal_reg;
    assign bubble_cnt = bubble_cnt_reg;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Directed testbench for id_ex_alu_issue; expected values are hand-derived from the instruction encodings.
module tb_id_ex_alu_issue;

    localparam logic [5:0] E_NONE = 6'd0;
    localparam logic [5:0] E_ADD  = 6'd1;
    localparam logic [5:0] E_SUB  = 6'd2;
    localparam logic [5:0] E_AND  = 6'd3;
    localparam logic [5:0] E_OR   = 6'd4;
    localparam logic [5:0] E_NOR  = 6'd5;
    localparam logic [5:0] E_SLT  = 6'd6;
    localparam logic [5:0] E_SLL  = 6'd7;
    localparam logic [5:0] E_SRL  = 6'd8;
    localparam logic [5:0] E_SRA  = 6'd9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] instr = 32'h0;
    logic [31:0] rs_val = 32'h0;
    logic [31:0] rt_val = 32'h0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        ex_valid;
    logic [31:0] ex_A;
    logic [31:0] ex_B;
    logic [5:0]  ex_ALUoper;
    logic        ex_wr_en;
    logic [4:0]  ex_wr_addr;
    logic        ex_illegal;
    logic [7:0]  bubble_cnt;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_cnt      = 0;

    always #5 clk = ~clk;

    id_ex_alu_issue #(.W(32), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .instr      (instr),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .stall      (stall),
        .flush      (flush),
        .ex_valid   (ex_valid),
        .ex_A       (ex_A),
        .ex_B       (ex_B),
        .ex_ALUoper (ex_ALUoper),
        .ex_wr_en   (ex_wr_en),
        .ex_wr_addr (ex_wr_addr),
        .ex_illegal (ex_illegal),
        .bubble_cnt (bubble_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock; bub says whether this edge should load a counted bubble
    task automatic tick(input bit bub);
        @(posedge clk);
        #1;
        if (rst) exp_cnt = 0;
        else if (bub && exp_cnt < 255) exp_cnt++;
        $display("[TB] t=%0t instr=%h iv=%b st=%b fl=%b -> v=%b op=%0d A=%h B=%h we=%b wa=%0d ill=%b cnt=%0d",
                 $time, instr, in_valid, stall, flush, ex_valid, ex_ALUoper, ex_A, ex_B,
                 ex_wr_en, ex_wr_addr, ex_illegal, bubble_cnt);
    endtask

    task automatic drive(input logic iv, input logic [31:0] ins,
                         input logic [31:0] rs, input logic [31:0] rt);
        in_valid = iv;
        instr    = ins;
        rs_val   = rs;
        rt_val   = rt;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [5:0] op,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic we, input logic [4:0] wa, input logic ill);
        check({tag, ".valid"}, {31'd0, ex_valid}, {31'd0, v});
        check({tag, ".op"},    {26'd0, ex_ALUoper}, {26'd0, op});
        check({tag, ".A"},     ex_A, a);
        check({tag, ".B"},     ex_B, b);
        check({tag, ".wr_en"}, {31'd0, ex_wr_en}, {31'd0, we});
        check({tag, ".wr_addr"}, {27'd0, ex_wr_addr}, {27'd0, wa});
        check({tag, ".illegal"}, {31'd0, ex_illegal}, {31'd0, ill});
        check({tag, ".cnt"},   {24'd0, bubble_cnt}, exp_cnt);
    endtask

    initial begin
        // reset
        tick(0);
        tick(0);
        check_out("reset", 0, E_NONE, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // R-type ALU ops
        drive(1, 32'h00221820, 32'h8000_00FA, 32'h4);
        tick(0);
        check_out("add", 1, E_ADD, 32'h8000_00FA, 32'h4, 1, 3, 0);
        drive(1, 32'h00022900, 32'h0, 32'h8000_00FA);
        tick(0);
        check_out("sll", 1, E_SLL, 32'h8000_00FA, 32'h4, 1, 5, 0);
        drive(1, 32'h00022902, 32'h0, 32'h1234_5678);
        tick(0);
        check_out("srl", 1, E_SRL, 32'h1234_5678, 32'h4, 1, 5, 0);
        drive(1, 32'h00022903, 32'h0, 32'hF000_0000);
        tick(0);
        check_out("sra", 1, E_SRA, 32'hF000_0000, 32'h4, 1, 5, 0);
        drive(1, 32'h00223822, 32'h11, 32'h22);
        tick(0);
        check_out("sub", 1, E_SUB, 32'h11, 32'h22, 1, 7, 0);
        drive(1, 32'h00223824, 32'hAA, 32'h0F);
        tick(0);
        check_out("and", 1, E_AND, 32'hAA, 32'h0F, 1, 7, 0);
        drive(1, 32'h00223825, 32'hA0, 32'h0B);
        tick(0);
        check_out("or", 1, E_OR, 32'hA0, 32'h0B, 1, 7, 0);
        drive(1, 32'h00223827, 32'h1, 32'h2);
        tick(0);
        check_out("nor", 1, E_NOR, 32'h1, 32'h2, 1, 7, 0);
        drive(1, 32'h0022382A, 32'hFFFF_FFFF, 32'h1);
        tick(0);
        check_out("slt", 1, E_SLT, 32'hFFFF_FFFF, 32'h1, 1, 7, 0);
        drive(1, 32'h00220020, 32'h5, 32'h6);
        tick(0);
        check_out("add_r0", 1, E_ADD, 32'h5, 32'h6, 0, 0, 0);

        // memory and branch
        drive(1, 32'h8C24FFF8, 32'd100, 32'h0);
        tick(0);
        check_out("lw", 1, E_ADD, 32'd100, 32'hFFFF_FFF8, 1, 4, 0);
        drive(1, 32'hAC24FFF8, 32'd100, 32'h77);
        tick(0);
        check_out("sw", 1, E_ADD, 32'd100, 32'hFFFF_FFF8, 0, 0, 0);
        drive(1, 32'h10220003, 32'h9, 32'h9);
        tick(0);
        check_out("beq", 1, E_SUB, 32'h9, 32'h9, 0, 0, 0);

        // stall freezes, stall+flush bubbles
        drive(1, 32'h00221820, 32'h8000_00FA, 32'h4);
        tick(0);
        check_out("pre_stall", 1, E_ADD, 32'h8000_00FA, 32'h4, 1, 3, 0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h00022900 + i, 32'h1 + i, 32'h2 + i);
            tick(0);
            check_out("stall_hold", 1, E_ADD, 32'h8000_00FA, 32'h4, 1, 3, 0);
        end
        flush = 1'b1;
        tick(1);
        check_out("stall_flush", 0, E_NONE, 0, 0, 0, 0, 0);
        stall = 1'b0;
        flush = 1'b0;

        // illegal opcode, held by stall, cleared by the next load
        drive(1, 32'hFC00_0000, 32'h1, 32'h2);
        tick(1);
        check_out("ill_op", 0, E_NONE, 0, 0, 0, 0, 1);
        stall = 1'b1;
        drive(1, 32'h00221820, 32'h3, 32'h4);
        tick(0);
        check_out("ill_stall", 0, E_NONE, 0, 0, 0, 0, 1);
        stall = 1'b0;
        tick(0);
        check_out("ill_clear", 1, E_ADD, 32'h3, 32'h4, 1, 3, 0);
        drive(1, 32'h0000_003F, 32'h3, 32'h4);
        tick(1);
        check_out("ill_funct", 0, E_NONE, 0, 0, 0, 0, 1);

        // long bubble stream: nop, in_valid=0, illegal opcode; counter saturates
        for (int i = 0; i < 300; i++) begin
            case (i % 3)
                0:       drive(1, 32'h0, 32'h5, 32'h6);
                1:       drive(0, 32'h00221820, 32'h5, 32'h6);
                default: drive(1, 32'hFC00_0000, 32'h5, 32'h6);
            endcase
            tick(1);
            check("stream.valid", {31'd0, ex_valid}, 32'd0);
            check("stream.illegal", {31'd0, ex_illegal}, {31'd0, (i % 3) == 2});
            check("stream.cnt", {24'd0, bubble_cnt}, exp_cnt);
        end
        check("sat_cnt", {24'd0, bubble_cnt}, 32'hFF);

        // I-type ALU ops
        drive(1, 32'h2022FFFF, 32'h10, 32'h0);
        tick(`ifdef IMM_ALU_OPS_EN 0 `else 1 `endif);
`ifdef IMM_ALU_OPS_EN
        check_out("addi", 1, E_ADD, 32'h10, 32'hFFFF_FFFF, 1, 2, 0);
`else
        check_out("addi", 0, E_NONE, 0, 0, 0, 0, 1);
`endif
        drive(1, 32'h3022FFFF, 32'h10, 32'h0);
        tick(`ifdef IMM_ALU_OPS_EN 0 `else 1 `endif);
`ifdef IMM_ALU_OPS_EN
        check_out("andi", 1, E_AND, 32'h10, 32'h0000_FFFF, 1, 2, 0);
`else
        check_out("andi", 0, E_NONE, 0, 0, 0, 0, 1);
`endif

        // reset while stalled
        drive(1, 32'h00221820, 32'h8000_00FA, 32'h4);
        tick(0);
        check_out("pre_rst", 1, E_ADD, 32'h8000_00FA, 32'h4, 1, 3, 0);
        stall = 1'b1;
        rst   = 1'b1;
        tick(0);
        check_out("rst_stall", 0, E_NONE, 0, 0, 0, 0, 0);
        rst   = 1'b0;
        stall = 1'b0;
        tick(0);
        check_out("post_rst", 1, E_ADD, 32'h8000_00FA, 32'h4, 1, 3, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
